// File: rtl/add_sub_arbiter_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
package add_sub_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_arbiter_addsub_core.sv
// Combinational WIDTH-bit ripple adder-subtractor (subtract = A + ~B + 1).
module addsub_core
  import add_sub_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MODE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;

  assign sub = (MODE == MODE_SUB);

  // Ripple carry chain; OVF compares carry into and out of the MSB
  always_comb begin
    SUM  = '0;
    c    = '0;
    bx   = B ^ {WIDTH{sub}};
    c[0] = sub;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      SUM[i]  = A[i] ^ bx[i] ^ c[i];
      c[i+1]  = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
    end
    COUT = c[WIDTH];
    OVF  = c[WIDTH] ^ c[WIDTH-1];
  end

endmodule

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one add/sub core between two requesters.
module add_sub_arbiter
  import add_sub_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic             MODE0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             REQ1,
  input  logic             MODE1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic             BUSY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  state_t           state, state_nx;
  logic             grant;
  logic             sel;
  logic             last;
  logic             op_port;
  logic             op_mode;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout, core_ovf;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .A    (op_a),
    .B    (op_b),
    .MODE (op_mode),
    .SUM  (core_sum),
    .COUT (core_cout),
    .OVF  (core_ovf)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Arbitration and next-state: a tie goes to the port that was not served last
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    sel      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          grant    = 1'b1;
          sel      = (REQ0 && REQ1) ? ~last : REQ1;
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture, grant/done pulses and result registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last    <= 1'b1;
      op_port <= 1'b0;
      op_mode <= MODE_ADD;
      op_a    <= '0;
      op_b    <= '0;
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      DONE0   <= 1'b0;
      DONE1   <= 1'b0;
      SUM     <= '0;
      COUT    <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            op_port <= sel;
            op_mode <= sel ? MODE1 : MODE0;
            op_a    <= sel ? A1 : A0;
            op_b    <= sel ? B1 : B0;
            last    <= sel;
            GNT0    <= ~sel;
            GNT1    <= sel;
          end
        end
        ST_EXEC: begin
          GNT0  <= 1'b0;
          GNT1  <= 1'b0;
          SUM   <= core_sum;
          COUT  <= core_cout;
          OVF   <= core_ovf;
          DONE0 <= ~op_port;
          DONE1 <= op_port;
        end
        ST_DONE: begin
          DONE0 <= 1'b0;
          DONE1 <= 1'b0;
        end
        default: begin
          GNT0  <= 1'b0;
          GNT1  <= 1'b0;
          DONE0 <= 1'b0;
          DONE1 <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: doc/add_sub_arbiter.md
Name: add_sub_arbiter

Overview:
- Shares one WIDTH-bit ripple adder-subtractor between two requesters (port 0, port 1).
- Round-robin arbitration; operands captured at grant; result, carry and signed overflow registered.
- Completion signalled by a one-cycle DONE pulse to the winning requester.
- Sits between two independent control FSMs and the single arithmetic resource.

Parameters:
WIDTH, 4, operand/result width in bits (minimum 2)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  reset, asynchronous, active-low
REQ0  input  1  requester 0 request, level
MODE0  input  1  requester 0 op: 0 = A+B, 1 = A-B
A0  input  WIDTH  requester 0 operand A
B0  input  WIDTH  requester 0 operand B
REQ1  input  1  requester 1 request, level
MODE1  input  1  requester 1 op
A1  input  WIDTH  requester 1 operand A
B1  input  WIDTH  requester 1 operand B
GNT0  output  1  pulse: requester 0 operands captured
GNT1  output  1  pulse: requester 1 operands captured
DONE0  output  1  pulse: result for requester 0 valid
DONE1  output  1  pulse: result for requester 1 valid
BUSY  output  1  high whenever state is not IDLE
SUM  output  WIDTH  registered result
COUT  output  1  carry out (sub: 1 = no borrow, A>=B unsigned)
OVF  output  1  signed overflow = carry into MSB xor carry out of MSB

Behaviour:
- Reset (RST_N low, async): state IDLE; GNT0/1, DONE0/1, BUSY, SUM, COUT, OVF = 0; operand registers = 0; LAST = 1, so port 0 wins the first tie.
- FSM IDLE -> EXEC -> DONE -> IDLE, one cycle per state except IDLE.
- IDLE:
  - Only one REQ high at edge E0: grant that port.
  - Both high: grant the port != LAST.
  - On grant at E0: latch MODE/A/B of the winner, set GNTx, update LAST, go to EXEC.
  - No REQ: stay in IDLE.
- EXEC:
  - GNTx high for this cycle only.
  - The core computes from the latched operands.
  - At E1: register SUM/COUT/OVF, clear GNTx, set DONEx, go to DONE.
- DONE:
  - DONEx high for this cycle only.
  - At E2: clear DONEx, go to IDLE.
  - Next arbitration edge is E3 at the earliest.
- Latency and throughput: REQ sampled at E0 -> DONE valid the cycle after E1 (2 cycles). One operation per 3 cycles.
- Handshake:
  - A requester holds REQ and operands until it sees GNT. After that its operands are don't-care.
  - It must drop REQ by the cycle its DONE is high, or it is re-arbitrated as a new request.
- SUM/COUT/OVF hold their last value until the next completion. They are not cleared at DONE exit.
- REQ or operand changes during EXEC/DONE are ignored. Never more than one GNT or DONE high at once.
- Arithmetic:
  - Subtraction = A + ~B + 1 (B xor MODE, carry-in = MODE).
  - SUM wraps modulo 2^WIDTH. No saturation.
- Starvation: a continuously requesting port waits at most one operation of the other port.
- Reset mid-operation: the in-flight result is discarded and no DONE is issued. After reset release, port 0 wins a tie.

Decomposition:
- Shared package: state encoding constants (IDLE, EXEC, DONE), MODE_ADD = 0, MODE_SUB = 1, default WIDTH.
- One sub-module, addsub_core: purely combinational WIDTH-bit ripple adder-subtractor.
  - Inputs: A, B, MODE.
  - Outputs: SUM, COUT, OVF.
  - A single instance is driven only from the latched operand registers.

Test Plan:
- Reset then REQ0 = 1, MODE0 = 0, A0 = 4'h3, B0 = 4'h4 -> GNT0 next cycle, then DONE0 with SUM = 4'h7, COUT = 0, OVF = 0; DONE1 never high.
- REQ1 only, MODE1 = 1, A1 = 4'h0, B1 = 4'h1 -> DONE1 with SUM = 4'hF, COUT = 0 (borrow), OVF = 0.
- REQ0 and REQ1 held high continuously from reset, A0 = 4'h7 + B0 = 4'h1, A1 = 4'hF + B1 = 4'h1, add -> grants alternate 0,1,0,1 every 3 cycles.
  - Port 0 result: SUM = 4'h8, OVF = 1, COUT = 0.
  - Port 1 result: SUM = 4'h0, COUT = 1, OVF = 0.
- After GNT0, change A0/B0/MODE0 and raise REQ1 during EXEC -> port 0 result uses the captured operands; port 1 granted only after DONE0, at E3.
- Assert RST_N low during EXEC -> all outputs 0 immediately (async), no DONE pulse; after release with both REQ high, port 0 granted first.
- Sweep all 2^(2*WIDTH) operand pairs for both modes through port 0 -> SUM/COUT/OVF match a reference model; SUM/COUT/OVF stable between DONE pulses.
